iaw_detect: RTL and testbench

//  Illegal-access watch detector: compares masked CPU writes/reads against a programmable

---
 rtl/iaw_pkg.sv | 33 +++
 rtl/iaw_range_cmp.sv | 20 ++
 rtl/iaw_detect.sv | 226 ++++++++++++++++++++++
 tb/tb_iaw_detect.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iaw_pkg.sv
// Package: iaw_pkg
// Shared definitions for the illegal-access watch detector.
//   - iaw_state_t : detector FSM states (IDLE / PULSE / COOL)
//   - SEL_*       : GRDSEL register-select codes
//   - CTRL_*      : bit positions inside the CTRL register
//   - SRC_*       : IAWSRC cause codes
package iaw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_COOL  = 2'd2
    } iaw_state_t;

    // GRDSEL codes
    localparam logic [1:0] SEL_LO   = 2'd0;
    localparam logic [1:0] SEL_HI   = 2'd1;
    localparam logic [1:0] SEL_CTRL = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    // CTRL register bit indices: {FGRD, RDGRD, WRGRD, EN}
    localparam int CTRL_EN    = 0;
    localparam int CTRL_WRGRD = 1;
    localparam int CTRL_RDGRD = 2;
    localparam int CTRL_FGRD  = 3;

    // IAWSRC cause codes
    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_WR    = 2'd1;
    localparam logic [1:0] SRC_RD    = 2'd2;
    localparam logic [1:0] SRC_FETCH = 2'd3;

endpackage

// File: rtl/iaw_range_cmp.sv
// Module: iaw_range_cmp
// Combinational inclusive unsigned window compare: in_win = LO <= ADR <= HI.
// A window with LO > HI can never satisfy both bounds, so it is empty.
// Ports:
//   lo     in  AW  lower bound (inclusive)
//   hi     in  AW  upper bound (inclusive)
//   adr    in  AW  address under test
//   in_win out 1   address inside the window
module iaw_range_cmp #(
    parameter int AW = 20
) (
    input  logic [AW-1:0] lo,
    input  logic [AW-1:0] hi,
    input  logic [AW-1:0] adr,
    output logic          in_win
);

    assign in_win = (adr >= lo) && (adr <= hi);

endmodule

// File: rtl/iaw_detect.sv
// Module: iaw_detect
// Illegal-access watch detector. Compares masked CPU writes / reads (and,
// optionally, instruction fetches) against a programmable guarded address
// window and raises IAWRES, a fixed-width reset-request pulse for the IAW
// interface, followed by a cooldown during which further hits cannot retrigger.
//
// Optional feature macro: IAW_FETCH_GUARD_EN
//   defined   : CTRL bit3 (FGRD) exists, fetch hits report IAWSRC=3
//   undefined : FGRD reads as 0, CPUFETCH is ignored
//
// Parameters: AW (address width), RES_W (pulse cycles, >=1),
//             COOL_W (cooldown cycles, >=0, 0 skips COOL)
// Ports:
//   FCLKRT    in   1   clock
//   RES       in   1   asynchronous reset, active-high
//   SVSTOPIAW in   1   suspend detection this cycle
//   CPUWRIAW  in   1   masked CPU write strobe
//   CPURD     in   1   CPU data read strobe
//   CPUFETCH  in   1   CPU fetch strobe
//   CPUADR    in   AW  access address
//   GRDWR     in   1   config write strobe
//   GRDSEL    in   2   config register select (LO/HI/CTRL/none)
//   GRDDAT    in   AW  config write data
//   IAWCLR    in   1   clear IAWFLAG / IAWSRC
//   IAWRES    out  1   reset request pulse (registered)
//   IAWFLAG   out  1   sticky illegal-access flag
//   IAWSRC    out  2   cause of first unacknowledged hit
module iaw_detect
    import iaw_pkg::*;
#(
    parameter int AW     = 20,
    parameter int RES_W  = 4,
    parameter int COOL_W = 8
) (
    input  logic          FCLKRT,
    input  logic          RES,
    input  logic          SVSTOPIAW,
    input  logic          CPUWRIAW,
    input  logic          CPURD,
    input  logic          CPUFETCH,
    input  logic [AW-1:0] CPUADR,
    input  logic          GRDWR,
    input  logic [1:0]    GRDSEL,
    input  logic [AW-1:0] GRDDAT,
    input  logic          IAWCLR,
    output logic          IAWRES,
    output logic          IAWFLAG,
    output logic [1:0]    IAWSRC
);

    localparam int CNT_MAX = (RES_W > COOL_W) ? RES_W : COOL_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RES_LOAD  = CNT_W'(RES_W - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'((COOL_W > 0) ? (COOL_W - 1) : 0);

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [AW-1:0] lo_reg;
    logic [AW-1:0] hi_reg;
    logic [2:0]    ctrl_reg;     // {RDGRD, WRGRD, EN}
    logic          fgrd;

    always_ff @(posedge FCLKRT or posedge RES) begin
        if (RES) begin
            lo_reg   <= '0;
            hi_reg   <= '0;
            ctrl_reg <= '0;
        end else if (GRDWR) begin
            case (GRDSEL)
                SEL_LO:   lo_reg   <= GRDDAT;
                SEL_HI:   hi_reg   <= GRDDAT;
                SEL_CTRL: ctrl_reg <= GRDDAT[2:0];
                default:  ;
            endcase
        end
    end

`ifdef IAW_FETCH_GUARD_EN
    logic fgrd_reg;

    always_ff @(posedge FCLKRT or posedge RES) begin
        if (RES) begin
            fgrd_reg <= 1'b0;
        end else if (GRDWR && (GRDSEL == SEL_CTRL)) begin
            fgrd_reg <= GRDDAT[CTRL_FGRD];
        end
    end

    assign fgrd = fgrd_reg;
`else
    // Fetch guarding is not built: FGRD is hard-wired off and the fetch
    // strobe is intentionally left without a consumer.
    logic unused_fetch;
    assign unused_fetch = CPUFETCH;
    assign fgrd         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Hit detection
    // ------------------------------------------------------------------
    logic       in_win;
    logic       wr_hit;
    logic       rd_hit;
    logic       fe_hit;
    logic       hit;
    logic [1:0] cause;

    iaw_range_cmp #(
        .AW (AW)
    ) u_range_cmp (
        .lo     (lo_reg),
        .hi     (hi_reg),
        .adr    (CPUADR),
        .in_win (in_win)
    );

    assign wr_hit = ctrl_reg[CTRL_WRGRD] & CPUWRIAW;
    assign rd_hit = ctrl_reg[CTRL_RDGRD] & CPURD;
    assign fe_hit = fgrd & CPUFETCH;
    assign hit    = ctrl_reg[CTRL_EN] & ~SVSTOPIAW & in_win & (wr_hit | rd_hit | fe_hit);

    // Coincident strobes report the highest-priority cause: write > read > fetch.
    always_comb begin
        cause = SRC_NONE;
        if (wr_hit) begin
            cause = SRC_WR;
        end else if (rd_hit) begin
            cause = SRC_RD;
        end else if (fe_hit) begin
            cause = SRC_FETCH;
        end
    end

    // ------------------------------------------------------------------
    // Sticky flag / first-cause capture
    // ------------------------------------------------------------------
    logic       flag_reg;
    logic [1:0] src_reg;

    always_ff @(posedge FCLKRT or posedge RES) begin
        if (RES) begin
            flag_reg <= 1'b0;
            src_reg  <= SRC_NONE;
        end else if (hit) begin
            // A hit outranks a concurrent clear; the clear frees IAWSRC to
            // take the new cause even though the flag stays set.
            flag_reg <= 1'b1;
            if (!flag_reg || IAWCLR) begin
                src_reg <= cause;
            end
        end else if (IAWCLR) begin
            flag_reg <= 1'b0;
            src_reg  <= SRC_NONE;
        end
    end

    assign IAWFLAG = flag_reg;
    assign IAWSRC  = src_reg;

    // ------------------------------------------------------------------
    // Pulse / cooldown FSM
    // ------------------------------------------------------------------
    iaw_state_t       state_reg;
    iaw_state_t       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             iawres_reg;
    logic             iawres_next;

    always_ff @(posedge FCLKRT or posedge RES) begin
        if (RES) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            iawres_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            iawres_reg <= iawres_next;
        end
    end

    // The counter holds "cycles remaining after this one" in the current state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (hit) begin
                    state_next = ST_PULSE;
                    cnt_next   = RES_LOAD;
                end
            end
            ST_PULSE: begin
                if (cnt_reg == '0) begin
                    if (COOL_W > 0) begin
                        state_next = ST_COOL;
                        cnt_next   = COOL_LOAD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_COOL: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        // Decoding the next state into a flop keeps IAWRES glitch-free.
        iawres_next = (state_next == ST_PULSE);
    end

    assign IAWRES = iawres_reg;

endmodule

// File: tb/tb_iaw_detect.sv
module tb_iaw_detect;

    localparam int AW     = 20;
    localparam int RES_W  = 4;
    localparam int COOL_W = 8;

    logic          fclk;
    logic          rst;
    logic          svstop;
    logic          cpuwr;
    logic          cpurd;
    logic          cpufetch;
    logic [AW-1:0] cpuadr;
    logic          grdwr;
    logic [1:0]    grdsel;
    logic [AW-1:0] grddat;
    logic          iawclr;
    logic          iawres;
    logic          iawflag;
    logic [1:0]    iawsrc;

    iaw_detect #(
        .AW     (AW),
        .RES_W  (RES_W),
        .COOL_W (COOL_W)
    ) dut (
        .FCLKRT    (fclk),
        .RES       (rst),
        .SVSTOPIAW (svstop),
        .CPUWRIAW  (cpuwr),
        .CPURD     (cpurd),
        .CPUFETCH  (cpufetch),
        .CPUADR    (cpuadr),
        .GRDWR     (grdwr),
        .GRDSEL    (grdsel),
        .GRDDAT    (grddat),
        .IAWCLR    (iawclr),
        .IAWRES    (iawres),
        .IAWFLAG   (iawflag),
        .IAWSRC    (iawsrc)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model + scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       res;
        logic       flag;
        logic [1:0] src;
    } exp_t;

    exp_t          sb_q[$];
    logic [AW-1:0] m_lo;
    logic [AW-1:0] m_hi;
    logic [3:0]    m_ctrl;
    logic          m_flag;
    logic [1:0]    m_src;
    int            m_t;      // 0 = idle, otherwise cycles since trigger (1-based)

    task automatic model_reset();
        m_lo   = '0;
        m_hi   = '0;
        m_ctrl = '0;
        m_flag = 1'b0;
        m_src  = 2'd0;
        m_t    = 0;
        sb_q.delete();
    endtask

    task automatic idle_inputs();
        svstop   = 1'b0;
        cpuwr    = 1'b0;
        cpurd    = 1'b0;
        cpufetch = 1'b0;
        cpuadr   = '0;
        grdwr    = 1'b0;
        grdsel   = 2'd3;
        grddat   = '0;
        iawclr   = 1'b0;
    endtask

    // Advance one clock with the currently driven inputs: predict, push,
    // clock, then pop and compare.
    task automatic tick();
        logic m_hit, in_win, w, r, f;
        logic [1:0] c;
        exp_t e;
        exp_t got;
        in_win = (cpuadr >= m_lo) && (cpuadr <= m_hi);
        w = m_ctrl[1] & cpuwr;
        r = m_ctrl[2] & cpurd;
`ifdef IAW_FETCH_GUARD_EN
        f = m_ctrl[3] & cpufetch;
`else
        f = 1'b0;
`endif
        m_hit = m_ctrl[0] & ~svstop & in_win & (w | r | f);
        c = w ? 2'd1 : (r ? 2'd2 : (f ? 2'd3 : 2'd0));
        if (m_t != 0) begin
            m_t++;
            if (m_t > RES_W + COOL_W) m_t = 0;
        end else if (m_hit) begin
            m_t = 1;
        end
        if (m_hit) begin
            if (!m_flag || iawclr) m_src = c;
            m_flag = 1'b1;
        end else if (iawclr) begin
            m_flag = 1'b0;
            m_src  = 2'd0;
        end
        if (grdwr) begin
            case (grdsel)
                2'd0: m_lo = grddat;
                2'd1: m_hi = grddat;
`ifdef IAW_FETCH_GUARD_EN
                2'd2: m_ctrl = grddat[3:0];
`else
                2'd2: m_ctrl = {1'b0, grddat[2:0]};
`endif
                default: ;
            endcase
        end
        e.res  = (m_t >= 1) && (m_t <= RES_W);
        e.flag = m_flag;
        e.src  = m_src;
        sb_q.push_back(e);

        @(posedge fclk);
        #1;
        cyc++;
        got = sb_q.pop_front();
        $display("[TB] cyc=%0d adr=0x%0h wr=%0b rd=%0b fe=%0b sv=%0b clr=%0b -> IAWRES=%0b FLAG=%0b SRC=%0d",
                 cyc, cpuadr, cpuwr, cpurd, cpufetch, svstop, iawclr, iawres, iawflag, iawsrc);
        check_val("iawres", 32'(iawres),  32'(got.res));
        check_val("iawflag", 32'(iawflag), 32'(got.flag));
        check_val("iawsrc", 32'(iawsrc),  32'(got.src));
        idle_inputs();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [AW-1:0] dat);
        grdwr  = 1'b1;
        grdsel = sel;
        grddat = dat;
        tick();
    endtask

    task automatic access(input logic w, input logic r, input logic f, input logic [AW-1:0] adr);
        cpuwr    = w;
        cpurd    = r;
        cpufetch = f;
        cpuadr   = adr;
        tick();
    endtask

    task automatic clear_flag();
        iawclr = 1'b1;
        tick();
    endtask

    localparam int DRAIN = RES_W + COOL_W + 1;

    initial begin
        int hi_cnt;
        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge fclk);
        #1;
        check_val("rst_iawres", 32'(iawres), 32'd0);
        check_val("rst_iawflag", 32'(iawflag), 32'd0);
        check_val("rst_iawsrc", 32'(iawsrc), 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // 1: basic write hit, count pulse width explicitly
        cfg(2'd0, 20'h100);
        cfg(2'd1, 20'h1FF);
        cfg(2'd2, 20'h3);
        access(1'b1, 1'b0, 1'b0, 20'h180);
        check_val("t1_first_res", 32'(iawres), 32'd1);
        hi_cnt = 1;
        for (int i = 0; i < DRAIN; i++) begin
            tick();
            if (iawres) hi_cnt++;
        end
        check_val("t1_pulse_width", 32'(hi_cnt), 32'(RES_W));
        clear_flag();

        // 2: outside the window and exact boundaries
        access(1'b1, 1'b0, 1'b0, 20'h200);
        access(1'b1, 1'b0, 1'b0, 20'h0FF);
        access(1'b1, 1'b0, 1'b0, 20'h1FF);
        idle_cycles(DRAIN);
        clear_flag();
        access(1'b1, 1'b0, 1'b0, 20'h100);
        idle_cycles(DRAIN);
        clear_flag();

        // 3: masked / disabled / empty-window cases
        svstop = 1'b1;
        access(1'b1, 1'b0, 1'b0, 20'h180);
        access(1'b0, 1'b1, 1'b0, 20'h180);
        cfg(2'd0, 20'h300);
        access(1'b1, 1'b0, 1'b0, 20'h180);
        access(1'b1, 1'b0, 1'b0, 20'h300);
        cfg(2'd0, 20'h100);
        idle_cycles(2);

        // 4: retrigger attempts during PULSE and COOL, then a fresh pulse
        cfg(2'd2, 20'h7);
        access(1'b1, 1'b0, 1'b0, 20'h180);
        idle_cycles(1);
        access(1'b0, 1'b1, 1'b0, 20'h1A0);        // during PULSE
        idle_cycles(4);
        access(1'b0, 1'b1, 1'b0, 20'h1A0);        // during COOL
        idle_cycles(DRAIN - 7);
        access(1'b1, 1'b0, 1'b0, 20'h180);        // after COOL
        idle_cycles(DRAIN);
        clear_flag();

        // 5: priority and clear-vs-hit
        access(1'b1, 1'b1, 1'b0, 20'h180);
        idle_cycles(DRAIN);
        iawclr = 1'b1;
        access(1'b0, 1'b1, 1'b0, 20'h180);
        idle_cycles(DRAIN);
        clear_flag();

        // 6: asynchronous reset in the second pulse cycle
        access(1'b1, 1'b0, 1'b0, 20'h180);
        tick();
        check_val("t6_pulse_before_rst", 32'(iawres), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_async_iawres", 32'(iawres), 32'd0);
        check_val("t6_async_iawflag", 32'(iawflag), 32'd0);
        model_reset();
        @(posedge fclk);
        #1;
        rst = 1'b0;
        idle_cycles(1);

        // 6b: fetch hit only when fetch guarding is built in
        cfg(2'd0, 20'h100);
        cfg(2'd1, 20'h1FF);
        cfg(2'd2, 20'hF);
        access(1'b0, 1'b0, 1'b1, 20'h180);
`ifdef IAW_FETCH_GUARD_EN
        check_val("t6_fetch_src", 32'(iawsrc), 32'd3);
`else
        check_val("t6_fetch_src", 32'(iawsrc), 32'd0);
`endif
        idle_cycles(DRAIN);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
